nvram_ctrl: RTL and testbench
=============================

# nvram_ctrl

Controller for the 256×4 non-volatile RAM selected by `NVRAMn`, modelling X2212 behaviour. It holds a working array, which the CPU reads and writes, and a shadow array, which is the non-volatile copy. It sequences STORE (working→shadow) and RECALL (shadow→working) block copies, including an automatic recall after reset. It arbitrates each array between the CPU, the copy engine and a host save/load port, and sits behind the address decoder beside the OUT1 latch that supplies STORE/RECALL.

## Interface
Parameters:
- `AW`, 8, address width; array depth is 2^AW.
- `DW`, 4, data width.
- `AUTO_RECALL`, 1, 1 = enter RECALL on reset; 0 = enter IDLE.

Ports:
- `CLK10` in 1: system clock.
- `RESET` in 1: synchronous, active-high reset.
- `NVRAMn` in 1: decoded NVRAM select, active low.
- `WRITEn` in 1: CPU write strobe, active low.
- `CPU_CE` in 1: one-cycle CPU access-complete strobe.
- `BA` in AW: CPU address.
- `BD_IN` in DW: CPU write data.
- `NV_DOUT` out DW: CPU read data, registered.
- `STORE` in 1: store request; rising edge triggers.
- `RECALL` in 1: recall request; rising edge triggers.
- `BUSY` out 1: high while a STORE or RECALL copy is in progress.
- `HOST_REQ` in 1: host access request; held until `HOST_ACK`.
- `HOST_WE` in 1: host write enable, qualified by `HOST_REQ`.
- `HOST_ADDR` in AW: host address into the shadow array.
- `HOST_DIN` in DW: host write data.
- `HOST_DOUT` out DW: host read data; valid while `HOST_ACK` is high.
- `HOST_ACK` out 1: one-cycle completion pulse.

## Operation
- Arrays are single-port: `work[2^AW]` and `shadow[2^AW]`. Shadow powers up all-zero.
- States: IDLE, RECALL, STORE, HOST. `BUSY` = (state is RECALL or STORE).
- CPU access = `~NVRAMn & CPU_CE`.
  - CPU access always wins the work array, in every state.
  - Write (`~WRITEn`): `work[BA] <= BD_IN`.
  - Every cycle `NVRAMn` is low, `NV_DOUT <= work[BA]`.
- Trigger edges are registered: `str_q`, `rcl_q`.
  - IDLE: a STORE edge enters STORE with cnt=0. A RECALL edge enters RECALL with cnt=0. If both edges arrive together, STORE wins.
  - Edges arriving in any other state are dropped.
- RECALL: each cycle with no CPU access, `work[cnt] <= shadow[cnt]` and cnt increments.
  - A CPU access stalls the copy for that cycle; cnt holds.
  - After copying cnt=2^AW−1, go to IDLE.
  - A CPU write to an address not yet copied is overwritten by the recall.
- STORE: each cycle with no CPU access, `shadow[cnt] <= work[cnt]` and cnt increments. Termination is the same as RECALL.
- HOST: entered from IDLE when `HOST_REQ` is high and no trigger edge is present this cycle. Trigger edges have priority over the host.
  - Next cycle: perform the shadow access, pulse `HOST_ACK`, present `HOST_DOUT = shadow[HOST_ADDR]` (read), then return to IDLE.
  - While HOST is active, the host owns the shadow array. The CPU is unaffected because it uses the work array.
- Reset:
  - Enter RECALL with cnt=0 if `AUTO_RECALL`=1, else IDLE.
  - `NV_DOUT`=0, `HOST_DOUT`=0, `HOST_ACK`=0, `BUSY`=`AUTO_RECALL`, `str_q`=`rcl_q`=1, so a level already high is not treated as an edge.
  - Array contents are preserved.
  - A reset during STORE aborts the copy, leaving the shadow partially updated.

## Timing
- CPU read: `NV_DOUT` is valid 1 cycle after the `BA`/`NVRAMn` sample.
- Copy: 2^AW cycles (256 by default) plus one cycle per CPU access stolen.
  - `BUSY` rises on the clock after the trigger edge is sampled.
  - `BUSY` falls on the clock after the last entry is copied.
- Host: `HOST_REQ` sampled in IDLE at cycle n; `HOST_ACK` at n+1. If the request is blocked by `BUSY`, the `HOST_ACK` pulse follows the first IDLE cycle.
- `HOST_REQ` must drop the cycle after `HOST_ACK`; if still high, a new access starts.

## Configuration
- `NVRAM_HOST_EN` defined: host port and HOST state are present, as described above.
- Not defined:
  - The HOST state is absent.
  - `HOST_REQ`, `HOST_WE`, `HOST_ADDR` and `HOST_DIN` are ignored.
  - `HOST_ACK` and `HOST_DOUT` are constant 0.
  - The port list is unchanged.

## Test plan
- Host writes shadow[0x10]=0xA, then pulse `RESET` (AUTO_RECALL=1) → `BUSY` high for 256 cycles; afterwards a CPU read of 0x10 gives `NV_DOUT`=0xA.
- CPU writes work[0x55]=0x3, then STORE edge → `BUSY` for 256 cycles; host read of 0x55 gives `HOST_ACK` with `HOST_DOUT`=0x3.
- STORE running, with a CPU access injected every 4th cycle → copy takes 256+stolen cycles, no entry is skipped, and the CPU data is correct.
- STORE and RECALL rising in the same cycle → STORE only; a RECALL edge during STORE is dropped, and work is unchanged afterward.
- `HOST_REQ` during RECALL → `HOST_ACK` only after `BUSY` falls; exactly one pulse.
- `RESET` at cnt=0x80 of STORE → shadow[0..0x7F] updated, shadow[0x80..] unchanged, and a RECALL restarts at cnt=0.

Source files
------------

// File: rtl/nvram_ctrl_if.sv
// CPU bus, STORE/RECALL triggers and host save/load port of the NVRAM controller.
// The host signals are always present; nvram_ctrl ignores them unless built with NVRAM_HOST_EN.
interface nvram_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 4
);
  logic          NVRAMn;
  logic          WRITEn;
  logic          CPU_CE;
  logic [AW-1:0] BA;
  logic [DW-1:0] BD_IN;
  logic [DW-1:0] NV_DOUT;
  logic          STORE;
  logic          RECALL;
  logic          BUSY;
  logic          HOST_REQ;
  logic          HOST_WE;
  logic [AW-1:0] HOST_ADDR;
  logic [DW-1:0] HOST_DIN;
  logic [DW-1:0] HOST_DOUT;
  logic          HOST_ACK;

  modport master (
    output NVRAMn, WRITEn, CPU_CE, BA, BD_IN, STORE, RECALL,
    output HOST_REQ, HOST_WE, HOST_ADDR, HOST_DIN,
    input  NV_DOUT, BUSY, HOST_DOUT, HOST_ACK
  );

  modport slave (
    input  NVRAMn, WRITEn, CPU_CE, BA, BD_IN, STORE, RECALL,
    input  HOST_REQ, HOST_WE, HOST_ADDR, HOST_DIN,
    output NV_DOUT, BUSY, HOST_DOUT, HOST_ACK
  );
endinterface

// File: rtl/nvram_ctrl.sv
// X2212-style NVRAM controller: working array, shadow array, STORE/RECALL block copies.
// Define NVRAM_HOST_EN to enable the host save/load port (HOST state) on the shadow array.
module nvram_ctrl #(
  parameter int AW          = 8,
  parameter int DW          = 4,
  parameter bit AUTO_RECALL = 1'b1
) (
  input logic         CLK10,
  input logic         RESET,
  nvram_ctrl_if.slave bus
);
  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECALL,
    S_STORE,
    S_HOST
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          str_q, rcl_q;
  logic          str_edge, rcl_edge;
  logic          cpu_acc;
  logic [DW-1:0] nv_dout_p1;

  logic [DW-1:0] work   [DEPTH];
  logic [DW-1:0] shadow [DEPTH];

  assign cpu_acc  = ~bus.NVRAMn & bus.CPU_CE;
  assign str_edge = bus.STORE  & ~str_q;
  assign rcl_edge = bus.RECALL & ~rcl_q;

  always_ff @(posedge CLK10) begin
    if (RESET) begin
      state <= (AUTO_RECALL != 1'b0) ? S_RECALL : S_IDLE;
      cnt   <= '0;
      str_q <= 1'b1;
      rcl_q <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      str_q <= bus.STORE;
      rcl_q <= bus.RECALL;
    end
  end

  // Trigger edges outrank the host; a CPU access steals the copy slot for one cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (str_edge) begin
          state_nxt = S_STORE;
          cnt_nxt   = '0;
        end else if (rcl_edge) begin
          state_nxt = S_RECALL;
          cnt_nxt   = '0;
        end
`ifdef NVRAM_HOST_EN
        else if (bus.HOST_REQ) begin
          state_nxt = S_HOST;
        end
`endif
      end
      S_RECALL, S_STORE: begin
        if (!cpu_acc) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_LAST) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.BUSY = (state == S_RECALL) || (state == S_STORE);

  // CPU owns the working array; recall only fills slots the CPU is not using.
  always_ff @(posedge CLK10) begin
    if (cpu_acc && !bus.WRITEn) begin
      work[bus.BA] <= bus.BD_IN;
    end else if (!RESET && state == S_RECALL && !cpu_acc) begin
      work[cnt] <= shadow[cnt];
    end
  end

  // A reset edge must not land one more store write, so the abort point is exact.
  always_ff @(posedge CLK10) begin
    if (!RESET && state == S_STORE && !cpu_acc) begin
      shadow[cnt] <= work[cnt];
    end
`ifdef NVRAM_HOST_EN
    else if (!RESET && state == S_HOST && bus.HOST_WE) begin
      shadow[bus.HOST_ADDR] <= bus.HOST_DIN;
    end
`endif
  end

  always_ff @(posedge CLK10) begin
    if (RESET) begin
      nv_dout_p1 <= '0;
    end else if (!bus.NVRAMn) begin
      nv_dout_p1 <= work[bus.BA];
    end
  end

  assign bus.NV_DOUT = nv_dout_p1;

`ifdef NVRAM_HOST_EN
  assign bus.HOST_ACK  = (state == S_HOST);
  assign bus.HOST_DOUT = (state == S_HOST && !bus.HOST_WE) ? shadow[bus.HOST_ADDR] : '0;
`else
  logic host_unused;
  assign host_unused   = ^{bus.HOST_REQ, bus.HOST_WE, bus.HOST_ADDR, bus.HOST_DIN};
  assign bus.HOST_ACK  = 1'b0;
  assign bus.HOST_DOUT = '0;
`endif
endmodule

// File: tb/tb_nvram_ctrl.sv
// Directed bench for nvram_ctrl: reset/auto-recall, CPU access, STORE/RECALL copies with
// stolen cycles, trigger priority, reset abort of STORE, and the host port (or its absence).
module tb_nvram_ctrl;
  localparam int AW = 8;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  nvram_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  nvram_ctrl #(.AW(AW), .DW(DW), .AUTO_RECALL(1'b1)) dut (
    .CLK10 (clk),
    .RESET (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pat1(input int a);
    logic [7:0] b;
    b = 8'(a);
    return 4'(b[3:0] + 4'(b[7:4] * 3) + 4'd1);
  endfunction

  function automatic logic [3:0] pat2(input int a);
    return ~pat1(a);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.NVRAMn = 1'b1;
    bus.CPU_CE = 1'b0;
    bus.WRITEn = 1'b1;
  endtask

  task automatic cpu_write(input int a, input logic [3:0] d);
    bus.NVRAMn = 1'b0;
    bus.CPU_CE = 1'b1;
    bus.WRITEn = 1'b0;
    bus.BA     = 8'(a);
    bus.BD_IN  = d;
    step();
    idle_bus();
  endtask

  task automatic cpu_read(input int a, output logic [3:0] d);
    bus.NVRAMn = 1'b0;
    bus.CPU_CE = 1'b1;
    bus.WRITEn = 1'b1;
    bus.BA     = 8'(a);
    step();
    d = bus.NV_DOUT;
    idle_bus();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.BUSY && n < 1000) begin
      step();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    int n, stolen, bad, acks;

    rst           = 1'b1;
    idle_bus();
    bus.BA        = '0;
    bus.BD_IN     = '0;
    bus.STORE     = 1'b1;
    bus.RECALL    = 1'b0;
    bus.HOST_REQ  = 1'b0;
    bus.HOST_WE   = 1'b0;
    bus.HOST_ADDR = '0;
    bus.HOST_DIN  = '0;
    step();
    step();
    check("reset_busy", bus.BUSY, 1);
    check("reset_nv_dout", bus.NV_DOUT, 0);
    check("reset_host_ack", bus.HOST_ACK, 0);
    check("reset_host_dout", bus.HOST_DOUT, 0);

    // Auto recall after reset; STORE held high through reset is not an edge
    rst = 1'b0;
    wait_idle(n);
    check("auto_recall_len", n, 256);
    step(); step(); step();
    check("store_level_no_edge", bus.BUSY, 0);
    bus.STORE = 1'b0;
    step();

    // Fill working array with pattern 1
    for (int a = 0; a < 256; a++) cpu_write(a, pat1(a));
    cpu_read(8'h00, d); check("rd_00", d, 4'h1);
    cpu_read(8'h55, d); check("rd_55", d, 4'h5);
    cpu_read(8'hFF, d); check("rd_ff", d, 4'hD);

    // STORE with a CPU read every 4th cycle; RECALL edge mid-copy is dropped
    bus.STORE = 1'b1;
    step();
    check("store_busy_rise", bus.BUSY, 1);
    n = 0; stolen = 0; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 10) bus.RECALL = 1'b1;
      if (i % 4 == 3) begin
        bus.NVRAMn = 1'b0;
        bus.CPU_CE = 1'b1;
        bus.WRITEn = 1'b1;
        bus.BA     = 8'(i);
      end else begin
        idle_bus();
      end
      step();
      n++;
      if (i % 4 == 3) begin
        stolen++;
        if (bus.NV_DOUT !== pat1(i & 255)) bad++;
      end
      if (!bus.BUSY) break;
    end
    idle_bus();
    check("store_stall_len", n, 341);
    check("store_stolen", stolen, 85);
    check("store_cpu_data", bad, 0);
    step(); step();
    check("recall_dropped", bus.BUSY, 0);
    bus.STORE  = 1'b0;
    bus.RECALL = 1'b0;
    step();

    // Overwrite work, then RECALL with CPU writes ahead of and behind the copy pointer
    for (int a = 0; a < 256; a++) cpu_write(a, pat2(a));
    cpu_read(8'h00, d); check("rd_pat2_00", d, 4'hE);
    bus.RECALL = 1'b1;
    step();
    check("recall_busy_rise", bus.BUSY, 1);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 2) begin
        bus.NVRAMn = 1'b0; bus.CPU_CE = 1'b1; bus.WRITEn = 1'b0;
        bus.BA = 8'hF0; bus.BD_IN = 4'h0;
      end else if (i == 20) begin
        bus.NVRAMn = 1'b0; bus.CPU_CE = 1'b1; bus.WRITEn = 1'b0;
        bus.BA = 8'h01; bus.BD_IN = 4'h9;
      end else begin
        idle_bus();
      end
      step();
      n++;
      if (!bus.BUSY) break;
    end
    idle_bus();
    check("recall_stall_len", n, 258);
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      cpu_read(a, d);
      if (d !== ((a == 1) ? 4'h9 : pat1(a))) bad++;
    end
    check("recall_all_entries", bad, 0);
    cpu_read(8'hF0, d); check("recall_overwrites_f0", d, 4'hE);
    cpu_read(8'h01, d); check("recall_keeps_01", d, 4'h9);
    bus.RECALL = 1'b0;
    step();

    // STORE and RECALL edges together: STORE only
    cpu_write(8'h20, 4'h5);
    bus.STORE  = 1'b1;
    bus.RECALL = 1'b1;
    step();
    check("simul_busy", bus.BUSY, 1);
    wait_idle(n);
    check("simul_len", n, 256);
    cpu_read(8'h20, d); check("simul_work_20", d, 4'h5);
    bus.STORE  = 1'b0;
    bus.RECALL = 1'b0;
    step();
    cpu_write(8'h20, 4'h0);
    bus.RECALL = 1'b1;
    step();
    wait_idle(n);
    bus.RECALL = 1'b0;
    cpu_read(8'h20, d); check("simul_shadow_20", d, 4'h5);
    step();

    // RESET at cnt=0x80 of a STORE aborts it and auto recall restarts at 0
    for (int a = 0; a < 256; a++) cpu_write(a, pat2(a));
    bus.STORE = 1'b1;
    step();
    for (int i = 0; i < 128; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.STORE = 1'b0;
    check("abort_recall_busy", bus.BUSY, 1);
    wait_idle(n);
    check("abort_recall_len", n, 256);
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      cpu_read(a, d);
      if (d !== ((a < 8'h80) ? pat2(a) : pat1(a))) bad++;
    end
    check("abort_all_entries", bad, 0);
    cpu_read(8'h7F, d); check("abort_rd_7f", d, 4'hA);
    cpu_read(8'h80, d); check("abort_rd_80", d, 4'h9);

`ifdef NVRAM_HOST_EN
    // Host write then read of the shadow array
    bus.HOST_REQ = 1'b1; bus.HOST_WE = 1'b1; bus.HOST_ADDR = 8'h10; bus.HOST_DIN = 4'hA;
    step();
    check("host_wr_ack", bus.HOST_ACK, 1);
    bus.HOST_REQ = 1'b0;
    step();
    check("host_wr_ack_drop", bus.HOST_ACK, 0);
    bus.HOST_REQ = 1'b1; bus.HOST_WE = 1'b0; bus.HOST_ADDR = 8'h80;
    step();
    check("host_rd_ack", bus.HOST_ACK, 1);
    check("host_rd_80", bus.HOST_DOUT, 4'h9);
    bus.HOST_REQ = 1'b0;
    step();
    // Host request during RECALL waits for BUSY to fall
    bus.RECALL = 1'b1;
    step();
    bus.HOST_REQ = 1'b1; bus.HOST_WE = 1'b0; bus.HOST_ADDR = 8'h10;
    n = 0; acks = 0;
    while (bus.BUSY && n < 1000) begin
      step();
      n++;
      if (bus.HOST_ACK) acks++;
    end
    check("host_blocked_acks", acks, 0);
    check("host_first_idle_ack", bus.HOST_ACK, 0);
    step();
    check("host_late_ack", bus.HOST_ACK, 1);
    check("host_rd_10", bus.HOST_DOUT, 4'hA);
    bus.HOST_REQ = 1'b0;
    step();
    check("host_single_pulse", bus.HOST_ACK, 0);
    bus.RECALL = 1'b0;
    cpu_read(8'h10, d); check("host_recalled_10", d, 4'hA);
`else
    bus.HOST_REQ = 1'b1; bus.HOST_WE = 1'b0; bus.HOST_ADDR = 8'h80;
    step();
    check("nohost_ack", bus.HOST_ACK, 0);
    check("nohost_dout", bus.HOST_DOUT, 0);
    step();
    check("nohost_ack2", bus.HOST_ACK, 0);
    check("nohost_busy", bus.BUSY, 0);
    bus.HOST_REQ = 1'b0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
